id_exe_stage_reg: RTL and testbench
===================================

# id_exe_stage_reg

Pipeline register between instruction decode and execute. Captures every decoded control bit, operand value, immediate field, destination and hazard source index from decode, plus the current carry flag, on each enabled clock edge. Supports freeze for memory stalls and flush for taken branches. Maintains a valid bit and a saturating count of squashed slots for performance debug.

## Interface
- `ADDRESS_LEN`, 32, width of PC and register values (from `configs.v`)
- `CNT_W`, 16, width of squash counter
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `freeze` in 1: hold all state (memory stall)
- `flush` in 1: insert bubble (branch taken in execute)
- `pc_in` in ADDRESS_LEN: PC+4 from decode
- `S_in`, `B_in`, `MEM_W_EN_in`, `MEM_R_EN_in`, `WB_EN_in` in 1 each: decode control bits
- `EXE_CMD_in` in 4: ALU command
- `Val_Rn_in`, `Val_Rm_in` in ADDRESS_LEN: register-file operands
- `imm_in` in 1, `Shift_operand_in` in 12, `Signed_imm_24_in` in 24, `Dest_in` in 4
- `src1_in`, `src2_in` in 4: source register indices for forwarding
- `C_in` in 1: carry from status register
- Outputs: same names without `_in`, same widths (`pc`, `S` … `src2`, `C`)
- `valid` out 1: slot holds a real, non-squashed instruction
- `squash_count` out CNT_W: bubbles inserted since reset, saturating

## Operation
- Priority on each rising edge: `rst` > `freeze` > `flush` > load.
- `rst`: every output is 0, including `valid` and `squash_count`.
- `freeze`: every register holds, including `valid` and the counter. A simultaneous `flush` is ignored. The branch in execute is frozen too and re-asserts `flush` once `freeze` drops.
- `flush`, no freeze:
  - All data and control outputs load 0.
  - `valid` is 0.
  - `squash_count` increments.
- Load, no freeze or flush:
  - All outputs load their `_in` values.
  - `C` loads `C_in`.
  - `valid` loads 1 unless `S_in`, `B_in`, `MEM_W_EN_in`, `MEM_R_EN_in` and `WB_EN_in` are all 0. That all-zero case is a decode-side bubble from a hazard or a failed condition.
  - In the all-zero case `valid` is 0, `squash_count` increments, and the data fields still load.
- `squash_count` saturates at 2^CNT_W−1 and never wraps.
- Outputs depend only on registers; no input→output combinational path.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- `freeze` held for k cycles means outputs stay constant for k cycles. Released at edge M: the load at edge M takes the inputs present then.
- `flush` for one cycle gives exactly one bubble. Back-to-back flushes give consecutive bubbles, and the counter advances once per edge.
- Reset during a held freeze still clears everything at that edge.
- Counter at max with another squash: it stays at max.

## Structure
- `ADDRESS_LEN` comes from the shared `configs.v`.
- The control-bundle width (9 bits: S, B, EXE_CMD[3:0], MEM_W_EN, MEM_R_EN, WB_EN) goes in the shared constants as `CTRL_BUNDLE_LEN`, so decode and execute agree on it.
- One sub-module: `Register` (parameterised width, `clk`, `rst`, `load`, `clear`). It is instantiated per field group: control bundle, operands, immediates/indices, carry+pc.
- `valid` and the counter are local logic.

## Test plan
- Reset then load: `rst`=1 for 2 cycles → all outputs 0. Then `WB_EN_in`=1, `EXE_CMD_in`=4'b0010, `Val_Rn_in`=32'h10, `Dest_in`=4'd3 → next cycle outputs match, `valid`=1, `squash_count`=0.
- Freeze hold: load `Val_Rm_in`=32'hAA, then `freeze`=1 for 3 cycles while inputs change to 32'hBB → `Val_Rm` stays 32'hAA. After release, the next edge shows 32'hBB.
- Flush vs freeze: `flush`=1 and `freeze`=1 together → no change, count unchanged. `flush` alone next cycle → all control 0, `valid`=0, `squash_count`=1.
- Decode bubble: all control inputs 0 with `Val_Rn_in`=32'h55 → `valid`=0, `squash_count` increments, `Val_Rn`=32'h55.
- Saturation with `CNT_W`=4: 17 consecutive flushes → count reaches 15 and stays there.
- Carry capture: `C_in`=1 on load → `C`=1. Freeze, then `C_in`=0 → `C` stays 1 until the next load.

Source files
------------

// File: rtl/id_exe_stage_reg_pkg.sv
// Shared decode/execute constants and the control bundle layout.
package id_exe_stage_reg_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int CTRL_BUNDLE_LEN = 9;

  // Ordering matches the packed control register: S, B, EXE_CMD, MEM_W_EN, MEM_R_EN, WB_EN
  typedef struct packed {
    logic       s;
    logic       b;
    logic [3:0] exe_cmd;
    logic       mem_w_en;
    logic       mem_r_en;
    logic       wb_en;
  } ctrl_bundle_t;

  // Decode signals a bubble by clearing every enable; EXE_CMD alone does not make a real op.
  function automatic logic is_decode_bubble(input ctrl_bundle_t c);
    return ~(c.s | c.b | c.mem_w_en | c.mem_r_en | c.wb_en);
  endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// Decode-to-execute bus: stage controls, decode-side fields and registered execute-side fields.
interface id_exe_stage_reg_if #(
  parameter int ADDRESS_LEN = 32,
  parameter int CNT_W       = 16
);
  logic                   freeze;
  logic                   flush;

  logic [ADDRESS_LEN-1:0] pc_in;
  logic                   S_in, B_in, MEM_W_EN_in, MEM_R_EN_in, WB_EN_in;
  logic [3:0]             EXE_CMD_in;
  logic [ADDRESS_LEN-1:0] Val_Rn_in, Val_Rm_in;
  logic                   imm_in;
  logic [11:0]            Shift_operand_in;
  logic [23:0]            Signed_imm_24_in;
  logic [3:0]             Dest_in, src1_in, src2_in;
  logic                   C_in;

  logic [ADDRESS_LEN-1:0] pc;
  logic                   S, B, MEM_W_EN, MEM_R_EN, WB_EN;
  logic [3:0]             EXE_CMD;
  logic [ADDRESS_LEN-1:0] Val_Rn, Val_Rm;
  logic                   imm;
  logic [11:0]            Shift_operand;
  logic [23:0]            Signed_imm_24;
  logic [3:0]             Dest, src1, src2;
  logic                   C;
  logic                   valid;
  logic [CNT_W-1:0]       squash_count;

  modport master (
    output freeze, flush, pc_in, S_in, B_in, MEM_W_EN_in, MEM_R_EN_in, WB_EN_in, EXE_CMD_in,
           Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in, Dest_in,
           src1_in, src2_in, C_in,
    input  pc, S, B, MEM_W_EN, MEM_R_EN, WB_EN, EXE_CMD, Val_Rn, Val_Rm, imm, Shift_operand,
           Signed_imm_24, Dest, src1, src2, C, valid, squash_count
  );

  modport slave (
    input  freeze, flush, pc_in, S_in, B_in, MEM_W_EN_in, MEM_R_EN_in, WB_EN_in, EXE_CMD_in,
           Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in, Dest_in,
           src1_in, src2_in, C_in,
    output pc, S, B, MEM_W_EN, MEM_R_EN, WB_EN, EXE_CMD, Val_Rn, Val_Rm, imm, Shift_operand,
           Signed_imm_24, Dest, src1, src2, C, valid, squash_count
  );
endinterface

// File: rtl/id_exe_stage_reg_register.sv
// Generic pipeline field register: reset wins, then a load that can be forced to zero.
module id_exe_stage_reg_register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold when not loading; clear turns a load into a bubble.
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= clear ? '0 : d;
  end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze, flush, valid tracking and a saturating squash counter.
module id_exe_stage_reg #(
  parameter int ADDRESS_LEN = id_exe_stage_reg_pkg::ADDRESS_LEN,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  id_exe_stage_reg_if.slave bus
);
  import id_exe_stage_reg_pkg::*;

  localparam int IMM_GRP_W = 1 + 12 + 24 + 4 + 4 + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                       load;
  logic                       squash_now;
  ctrl_bundle_t               ctrl_d, ctrl_q;
  logic [2*ADDRESS_LEN-1:0]   opnd_q;
  logic [IMM_GRP_W-1:0]       imm_grp_q;
  logic [ADDRESS_LEN:0]       cpc_q;
  logic                       valid_q;
  logic [CNT_W-1:0]           cnt_q;

  // Freeze stalls every group at once, so one load enable serves all of them.
  assign load   = ~bus.freeze;
  assign ctrl_d = {bus.S_in, bus.B_in, bus.EXE_CMD_in, bus.MEM_W_EN_in, bus.MEM_R_EN_in, bus.WB_EN_in};

  // A slot is squashed by an execute-side flush or by decode handing over a bubble.
  assign squash_now = bus.flush | is_decode_bubble(ctrl_d);

  id_exe_stage_reg_register #(.WIDTH(CTRL_BUNDLE_LEN)) u_ctrl (
    .clk(clk), .rst(rst), .load(load), .clear(bus.flush),
    .d(ctrl_d), .q(ctrl_q)
  );

  id_exe_stage_reg_register #(.WIDTH(2*ADDRESS_LEN)) u_opnd (
    .clk(clk), .rst(rst), .load(load), .clear(bus.flush),
    .d({bus.Val_Rn_in, bus.Val_Rm_in}), .q(opnd_q)
  );

  id_exe_stage_reg_register #(.WIDTH(IMM_GRP_W)) u_imm (
    .clk(clk), .rst(rst), .load(load), .clear(bus.flush),
    .d({bus.imm_in, bus.Shift_operand_in, bus.Signed_imm_24_in, bus.Dest_in, bus.src1_in, bus.src2_in}),
    .q(imm_grp_q)
  );

  id_exe_stage_reg_register #(.WIDTH(ADDRESS_LEN+1)) u_cpc (
    .clk(clk), .rst(rst), .load(load), .clear(bus.flush),
    .d({bus.C_in, bus.pc_in}), .q(cpc_q)
  );

  // Valid follows each load; the counter bumps once per squashed slot and sticks at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      valid_q <= ~squash_now;
      if (squash_now && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign {bus.S, bus.B, bus.EXE_CMD, bus.MEM_W_EN, bus.MEM_R_EN, bus.WB_EN} = ctrl_q;
  assign {bus.Val_Rn, bus.Val_Rm} = opnd_q;
  assign {bus.imm, bus.Shift_operand, bus.Signed_imm_24, bus.Dest, bus.src1, bus.src2} = imm_grp_q;
  assign {bus.C, bus.pc} = cpc_q;
  assign bus.valid        = valid_q;
  assign bus.squash_count = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed plus random bench for id_exe_stage_reg against a slot-level reference model.
module tb_id_exe_stage_reg;

  localparam int AL = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        S, B;
    logic [3:0]  EXE_CMD;
    logic        MEM_W_EN, MEM_R_EN, WB_EN;
    logic [31:0] pc, Val_Rn, Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest, src1, src2;
    logic        C;
  } slot_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_exe_stage_reg_if #(.ADDRESS_LEN(AL), .CNT_W(CW)) bus ();

  id_exe_stage_reg #(.ADDRESS_LEN(AL), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int    errors = 0;
  int    checks = 0;
  slot_t m_slot;
  logic  m_valid;
  int    m_cnt;

  function automatic slot_t in_slot();
    slot_t s;
    s = {bus.S_in, bus.B_in, bus.EXE_CMD_in, bus.MEM_W_EN_in, bus.MEM_R_EN_in, bus.WB_EN_in,
         bus.pc_in, bus.Val_Rn_in, bus.Val_Rm_in, bus.imm_in, bus.Shift_operand_in,
         bus.Signed_imm_24_in, bus.Dest_in, bus.src1_in, bus.src2_in, bus.C_in};
    return s;
  endfunction

  function automatic slot_t out_slot();
    slot_t s;
    s = {bus.S, bus.B, bus.EXE_CMD, bus.MEM_W_EN, bus.MEM_R_EN, bus.WB_EN,
         bus.pc, bus.Val_Rn, bus.Val_Rm, bus.imm, bus.Shift_operand,
         bus.Signed_imm_24, bus.Dest, bus.src1, bus.src2, bus.C};
    return s;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input slot_t obs, input slot_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a slot is a real instruction when any enable is set; squashes saturate.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_slot = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (!bus.freeze) begin
      if (bus.flush) begin
        m_slot = '0; m_valid = 1'b0;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else begin
        m_slot  = in_slot();
        m_valid = bus.S_in | bus.B_in | bus.MEM_W_EN_in | bus.MEM_R_EN_in | bus.WB_EN_in;
        if (!m_valid) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end
    #1;
    chk_slot("slot", out_slot(), m_slot);
    chk32("valid", 32'(bus.valid), 32'(m_valid));
    chk32("squash_count", 32'(bus.squash_count), m_cnt);
  endtask

  task automatic zero_inputs();
    bus.pc_in = '0; bus.S_in = 0; bus.B_in = 0; bus.MEM_W_EN_in = 0; bus.MEM_R_EN_in = 0;
    bus.WB_EN_in = 0; bus.EXE_CMD_in = '0; bus.Val_Rn_in = '0; bus.Val_Rm_in = '0;
    bus.imm_in = 0; bus.Shift_operand_in = '0; bus.Signed_imm_24_in = '0; bus.Dest_in = '0;
    bus.src1_in = '0; bus.src2_in = '0; bus.C_in = 0;
  endtask

  task automatic rand_inputs();
    bus.pc_in = $urandom; bus.Val_Rn_in = $urandom; bus.Val_Rm_in = $urandom;
    bus.EXE_CMD_in = 4'($urandom); bus.imm_in = 1'($urandom);
    bus.Shift_operand_in = 12'($urandom); bus.Signed_imm_24_in = 24'($urandom);
    bus.Dest_in = 4'($urandom); bus.src1_in = 4'($urandom); bus.src2_in = 4'($urandom);
    bus.C_in = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      bus.S_in = 0; bus.B_in = 0; bus.MEM_W_EN_in = 0; bus.MEM_R_EN_in = 0; bus.WB_EN_in = 0;
    end else begin
      bus.S_in = 1'($urandom); bus.B_in = 1'($urandom); bus.MEM_W_EN_in = 1'($urandom);
      bus.MEM_R_EN_in = 1'($urandom); bus.WB_EN_in = 1'($urandom);
    end
    bus.freeze = ($urandom_range(0, 3) == 0);
    bus.flush  = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    m_slot = '0; m_valid = 1'b0; m_cnt = 0;
    rst = 1'b1; bus.freeze = 0; bus.flush = 0;
    zero_inputs();

    // reset for two cycles
    tick(); tick();
    chk32("rst_valid", 32'(bus.valid), 32'd0);
    chk32("rst_count", 32'(bus.squash_count), 32'd0);

    // first load
    rst = 1'b0;
    bus.WB_EN_in = 1; bus.EXE_CMD_in = 4'b0010; bus.Val_Rn_in = 32'h10; bus.Dest_in = 4'd3;
    tick();
    chk32("load_val_rn", bus.Val_Rn, 32'h10);
    chk32("load_exe_cmd", 32'(bus.EXE_CMD), 32'h2);
    chk32("load_dest", 32'(bus.Dest), 32'd3);
    chk32("load_valid", 32'(bus.valid), 32'd1);

    // freeze holds
    bus.Val_Rm_in = 32'hAA;
    tick();
    bus.freeze = 1; bus.Val_Rm_in = 32'hBB;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("freeze_hold", bus.Val_Rm, 32'hAA);
    end
    bus.freeze = 0;
    tick();
    chk32("freeze_release", bus.Val_Rm, 32'hBB);

    // flush ignored under freeze, then honoured alone
    bus.freeze = 1; bus.flush = 1;
    tick();
    chk32("flush_frozen_count", 32'(bus.squash_count), 32'd0);
    chk32("flush_frozen_valid", 32'(bus.valid), 32'd1);
    bus.freeze = 0;
    tick();
    chk32("flush_wb", 32'(bus.WB_EN), 32'd0);
    chk32("flush_valid", 32'(bus.valid), 32'd0);
    chk32("flush_count", 32'(bus.squash_count), 32'd1);

    // decode-side bubble still loads data
    bus.flush = 0; bus.WB_EN_in = 0; bus.EXE_CMD_in = 4'h7; bus.Val_Rn_in = 32'h55;
    tick();
    chk32("bubble_valid", 32'(bus.valid), 32'd0);
    chk32("bubble_count", 32'(bus.squash_count), 32'd2);
    chk32("bubble_val_rn", bus.Val_Rn, 32'h55);

    // carry capture and hold
    bus.WB_EN_in = 1; bus.C_in = 1;
    tick();
    chk32("carry_load", 32'(bus.C), 32'd1);
    bus.freeze = 1; bus.C_in = 0;
    tick(); tick();
    chk32("carry_hold", 32'(bus.C), 32'd1);
    bus.freeze = 0;
    tick();
    chk32("carry_next", 32'(bus.C), 32'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end

    // reset during freeze
    rand_inputs();
    bus.WB_EN_in = 1; bus.freeze = 0; bus.flush = 0; rst = 0;
    tick();
    bus.freeze = 1; rst = 1;
    tick();
    chk32("rst_in_freeze_valid", 32'(bus.valid), 32'd0);
    chk32("rst_in_freeze_pc", bus.pc, 32'd0);

    // saturation: 17 flushes from a clean counter
    bus.freeze = 0; bus.flush = 0;
    tick();
    rst = 0; bus.flush = 1;
    for (int i = 0; i < 17; i++) tick();
    chk32("sat_count", 32'(bus.squash_count), 32'd15);
    bus.flush = 0; zero_inputs();
    tick();
    chk32("sat_hold", 32'(bus.squash_count), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
